// File: rtl/fifo_4w_wr_sched_pkg.sv
// Shared types and helpers for the 4-write-port FIFO write scheduler.
// Provides the slot count, slot-index type, popcount4 and min_cap.
package fifo_4w_sched_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_idx_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

    // Negative credit clamps to zero; more than one cycle's worth of
    // slots clamps to the slot count.
    function automatic logic [2:0] min_cap(input int free);
        if (free <= 0) return 3'd0;
        else if (free >= NUM_SLOTS) return 3'd4;
        else return 3'(free);
    endfunction

endpackage

// File: rtl/fifo_4w_wr_sched_rr_pick4.sv
// Combinational round-robin picker: grants up to cap requesters from rr_ptr.
// Ports: req_i, rr_ptr_i, cap_i -> grant_o, slot_req_o, slot_val_o, next_ptr_o.
module rr_pick4
    import fifo_4w_sched_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [PTR_W-1:0]                  rr_ptr_i,
    input  logic [2:0]                        cap_i,
    output logic [NUM_REQ-1:0]                grant_o,
    output logic [NUM_SLOTS-1:0][PTR_W-1:0]   slot_req_o,
    output logic [NUM_SLOTS-1:0]              slot_val_o,
    output logic [PTR_W-1:0]                  next_ptr_o
);

    always_comb begin
        int idx;
        int cnt;
        int last;
        slot_idx_t s;
        grant_o    = '0;
        slot_req_o = '0;
        slot_val_o = '0;
        next_ptr_o = rr_ptr_i;
        idx        = 0;
        cnt        = 0;
        last       = 0;
        s          = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr_ptr_i) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            // cnt tracks the next free slot, so slots fill contiguously
            if (req_i[idx] && (cnt < int'(cap_i))) begin
                s              = slot_idx_t'(cnt);
                grant_o[idx]   = 1'b1;
                slot_req_o[s]  = PTR_W'(idx);
                slot_val_o[s]  = 1'b1;
                cnt            = cnt + 1;
                last           = idx;
            end
        end
        if (cnt != 0) begin
            next_ptr_o = (last == NUM_REQ - 1) ? '0 : PTR_W'(last + 1);
        end
    end

endmodule

// File: rtl/fifo_4w_wr_sched.sv
// Write-side scheduler sharing one 4-write-port FIFO among NUM_REQ requesters.
// Ports: clk, rst, sched_en, req_val/req_data/req_rdy, fifo_size, w_val_0..3, w_data_0..3.
// Optional macro FIFO_4W_WR_SCHED_STATS_EN adds grant_cnt and stall_cnt outputs.
module fifo_4w_wr_sched
    import fifo_4w_sched_pkg::*;
#(
    parameter int NUM_REQ    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sched_en,
    input  logic [NUM_REQ-1:0]            req_val,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [CNT_WIDTH-1:0]          fifo_size,
    output logic                          w_val_0,
    output logic                          w_val_1,
    output logic                          w_val_2,
    output logic                          w_val_3,
    output logic [DATA_WIDTH-1:0]         w_data_0,
    output logic [DATA_WIDTH-1:0]         w_data_1,
    output logic [DATA_WIDTH-1:0]         w_data_2,
    output logic [DATA_WIDTH-1:0]         w_data_3
`ifdef FIFO_4W_WR_SCHED_STATS_EN
    ,
    output logic [31:0]                   grant_cnt,
    output logic [31:0]                   stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [NUM_SLOTS-1:0]                  w_val_q, w_val_d;
    logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0]  w_data_q, w_data_d;

    logic [2:0]                            cap;
    logic [NUM_SLOTS-1:0][PTR_W-1:0]       slot_req;
    logic [NUM_SLOTS-1:0]                  slot_val;

    // Writes still sitting in the output register are not yet counted
    // in fifo_size, so they are subtracted from the credit.
    always_comb begin
        int free;
        free = (FIFO_DEPTH - 1) - int'(fifo_size) - int'(popcount4(w_val_q));
        cap  = (sched_en && !rst) ? min_cap(free) : 3'd0;
    end

    rr_pick4 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i      (req_val),
        .rr_ptr_i   (rr_ptr_q),
        .cap_i      (cap),
        .grant_o    (req_rdy),
        .slot_req_o (slot_req),
        .slot_val_o (slot_val),
        .next_ptr_o (rr_ptr_d)
    );

    always_comb begin
        w_val_d  = slot_val;
        w_data_d = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_val[k]) begin
                w_data_d[k] = req_data[int'(slot_req[k])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            w_val_q  <= '0;
            w_data_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            w_val_q  <= w_val_d;
            w_data_q <= w_data_d;
        end
    end

    assign w_val_0  = w_val_q[0];
    assign w_val_1  = w_val_q[1];
    assign w_val_2  = w_val_q[2];
    assign w_val_3  = w_val_q[3];
    assign w_data_0 = w_data_q[0];
    assign w_data_1 = w_data_q[1];
    assign w_data_2 = w_data_q[2];
    assign w_data_3 = w_data_q[3];

`ifdef FIFO_4W_WR_SCHED_STATS_EN
    logic [31:0] grant_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall;

    assign stall = (|req_val) && sched_en && (cap == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_q + 32'(popcount4(slot_val));
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
